parity_rx: RTL and testbench

Serial receiver for the team's parity-protected nibble link. It samples a single-wire frame made of a start bit, DATA_W data bits sent LSB first, one even/odd parity bit and a stop bit. It deserializes the word, checks parity and stop-bit framing, and presents the result with a one-cycle valid strobe. It is the far end of the parity generator path: the generator computes the parity bit, and this block recovers and checks it after serial transport.

---
 rtl/parity_pkg.sv | 14 +
 rtl/parity_rx_sync.sv | 15 +
 rtl/parity_rx.sv | 108 ++++++++++
 tb/tb_parity_rx.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/parity_pkg.sv
// parity_pkg: shared types and helpers for the parity-protected serial link
// Contents: rx_state_t receiver states, bit-index helpers, parity_calc shared with the generator.
package parity_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} rx_state_t;
  function automatic int parity_idx(input int data_w);
    return data_w + 1;
  endfunction
  function automatic int stop_idx(input int data_w);
    return data_w + 2;
  endfunction
  function automatic logic parity_calc(input logic [31:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction
endpackage

// File: rtl/parity_rx_sync.sv
// rx_sync: two-flop synchronizer resetting to 1 (idle line level)
// Ports: clk, rst (sync, active high), d (async input), q (synchronized output).
module rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta_q, sync_q;
  always_ff @(posedge clk) begin
    meta_q <= rst ? 1'b1 : d;
    sync_q <= rst ? 1'b1 : meta_q;
  end
  assign q = sync_q;
endmodule

// File: rtl/parity_rx.sv
// parity_rx: serial receiver for start/data/parity/stop frames with parity and framing checks
// Ports: clk, rst (sync, active high), rxd (serial in, idle high), data (last word),
//        valid (1-cycle strobe), parity_err, frame_err, busy (frame in progress).
// Optional: define PARITY_RX_SYNC_EN to pass rxd through a two-flop synchronizer first.
module parity_rx
  import parity_pkg::*;
#(
  parameter int DATA_W       = 4,
  parameter int CLKS_PER_BIT = 4,
  parameter bit ODD          = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rxd,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_W + 3);
  localparam int PARITY_IDX = parity_idx(DATA_W);
  logic rx;
`ifdef PARITY_RX_SYNC_EN
  rx_sync u_sync (.clk(clk), .rst(rst), .d(rxd), .q(rx));
`else
  assign rx = rxd;
`endif
  rx_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d, data_q, data_d;
  logic par_q, par_d, perr_q, perr_d, ferr_q, ferr_d, valid_q, valid_d;
  logic sample;
  // The start bit is checked half a bit in; every later sample is a full bit apart.
  assign sample = (state_q == START) ? (cnt_q == CW'(CLKS_PER_BIT/2 - 1))
                                     : (cnt_q == CW'(CLKS_PER_BIT - 1));
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    data_d  = data_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    valid_d = 1'b0;
    cnt_d   = (state_q == IDLE || state_q == BREAK || sample) ? '0 : cnt_q + 1'b1;
    case (state_q)
      IDLE: if (!rx) begin
        state_d = START;
        bit_d   = '0;
      end
      START: if (sample) begin
        state_d = rx ? IDLE : DATA;
        bit_d   = rx ? '0 : BW'(1);
      end
      DATA: if (sample) begin
        shift_d = (shift_q >> 1) | (DATA_W'(rx) << (DATA_W - 1));
        bit_d   = bit_q + 1'b1;
        state_d = (bit_q == BW'(PARITY_IDX - 1)) ? PARITY : DATA;
      end
      PARITY: if (sample) begin
        par_d   = rx;
        bit_d   = bit_q + 1'b1;
        state_d = STOP;
      end
      STOP: if (sample) begin
        data_d  = shift_q;
        perr_d  = parity_calc(32'(shift_q), ODD) != par_q;
        ferr_d  = ~rx;
        valid_d = 1'b1;
        bit_d   = '0;
        state_d = rx ? IDLE : BREAK;
      end
      BREAK: state_d = rx ? IDLE : BREAK;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      data_q  <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      data_q  <= data_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      valid_q <= valid_d;
    end
  end
  assign data       = data_q;
  assign valid      = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign busy       = state_q != IDLE;
endmodule

// File: tb/tb_parity_rx.sv
// tb_parity_rx: directed table-driven bench for parity_rx (DATA_W=4, CLKS_PER_BIT=4, even parity)
module tb_parity_rx;
  localparam int CPB = 4;
  localparam int LAT = CPB/2 + 6*CPB;
  logic clk = 1'b0, rst = 1'b1, rxd = 1'b1;
  logic [3:0] data;
  logic valid, parity_err, frame_err, busy;
  int cyc = 0, n_cmp = 0, n_err = 0;
  typedef struct {int c; logic [3:0] d; logic pe, fe, bz;} rec_t;
  rec_t vq[$];
  typedef struct {logic [3:0] d; logic par, stp; logic [3:0] ed; logic epe, efe;} vec_t;
  vec_t tbl[6];

  parity_rx #(.DATA_W(4), .CLKS_PER_BIT(CPB), .ODD(1'b0)) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .data(data), .valid(valid),
    .parity_err(parity_err), .frame_err(frame_err), .busy(busy));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (valid) vq.push_back('{cyc, data, parity_err, frame_err, busy});

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic send(input logic [3:0] d, input logic par, input logic stp, output int t0);
    logic [6:0] bits;
    bits = {stp, par, d, 1'b0};
    t0 = cyc + 1;
    for (int i = 0; i < 7; i++) begin
      rxd = bits[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic expect_one(input string nm, input int t0, input logic [3:0] d,
                            input logic pe, input logic fe, input logic bz);
    rec_t r;
    chk({nm, " count"}, vq.size(), 1);
    if (vq.size() > 0) begin
      r = vq.pop_front();
      chk({nm, " latency"}, r.c - t0, LAT);
      chk({nm, " data"}, r.d, d);
      chk({nm, " parity_err"}, r.pe, pe);
      chk({nm, " frame_err"}, r.fe, fe);
      chk({nm, " busy"}, r.bz, bz);
    end
    vq.delete();
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, " data"}, data, 0);
    chk({nm, " valid"}, valid, 0);
    chk({nm, " parity_err"}, parity_err, 0);
    chk({nm, " frame_err"}, frame_err, 0);
    chk({nm, " busy"}, busy, 0);
  endtask

  initial begin
    int t0, t1;
    rec_t r;
    tbl[0] = '{4'b1101, 1'b1, 1'b1, 4'b1101, 1'b0, 1'b0};
    tbl[1] = '{4'b1010, 1'b1, 1'b1, 4'b1010, 1'b1, 1'b0};
    tbl[2] = '{4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0};
    tbl[3] = '{4'b1111, 1'b1, 1'b1, 4'b1111, 1'b1, 1'b0};
    tbl[4] = '{4'b0111, 1'b1, 1'b1, 4'b0111, 1'b0, 1'b0};
    tbl[5] = '{4'b1000, 1'b0, 1'b1, 4'b1000, 1'b1, 1'b0};
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    vq.delete();
    for (int k = 0; k < 6; k++) begin
      send(tbl[k].d, tbl[k].par, tbl[k].stp, t0);
      rxd = 1'b1;
      repeat (3) @(negedge clk);
      expect_one($sformatf("vec%0d", k), t0, tbl[k].ed, tbl[k].epe, tbl[k].efe, 1'b0);
    end
    // stop bit low, line held in break
    send(4'b0000, 1'b0, 1'b0, t0);
    repeat (20) @(negedge clk);
    chk("break busy", busy, 1);
    expect_one("break", t0, 4'b0000, 1'b0, 1'b1, 1'b1);
    rxd = 1'b1;
    repeat (2) @(negedge clk);
    chk("break exit busy", busy, 0);
    send(4'b0110, 1'b0, 1'b1, t0);
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    expect_one("after_break", t0, 4'b0110, 1'b0, 1'b0, 1'b0);
    // one-cycle glitch: false start
    rxd = 1'b0;
    @(negedge clk);
    rxd = 1'b1;
    chk("glitch busy t0", busy, 1);
    repeat (2) @(negedge clk);
    chk("glitch busy t0+2", busy, 0);
    repeat (30) @(negedge clk);
    chk("glitch no valid", vq.size(), 0);
    vq.delete();
    // reset in the middle of data bit 2 (leaves nonzero outputs before)
    send(4'b1000, 1'b0, 1'b1, t0);
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    vq.delete();
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    rxd = 1'b1;
    repeat (2*CPB + 2) @(negedge clk);
    chk("pre-reset busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk_zero("midframe reset");
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("aborted no valid", vq.size(), 0);
    vq.delete();
    send(4'b1111, 1'b0, 1'b1, t0);
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    expect_one("post_reset", t0, 4'b1111, 1'b0, 1'b0, 1'b0);
    // back-to-back frames
    send(4'b0011, 1'b0, 1'b1, t0);
    send(4'b1000, 1'b1, 1'b1, t1);
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    chk("b2b count", vq.size(), 2);
    if (vq.size() == 2) begin
      chk("b2b spacing", vq[1].c - vq[0].c, 28);
      r = vq.pop_front();
      chk("b2b0 latency", r.c - t0, LAT);
      chk("b2b0 data", r.d, 4'b0011);
      chk("b2b0 errs", {r.pe, r.fe}, 0);
      r = vq.pop_front();
      chk("b2b1 latency", r.c - t1, LAT);
      chk("b2b1 data", r.d, 4'b1000);
      chk("b2b1 errs", {r.pe, r.fe}, 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
